// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: colour codes, FSM states and colour decode shared by the LED arbiter
package rgb_led_pkg;

    typedef enum logic [2:0] {RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA, WHITE, OFF} color_t;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    // Returns {r,g,b}
    function automatic logic [2:0] decode_color(color_t c);
        case (c)
            RED:     return 3'b100;
            YELLOW:  return 3'b110;
            GREEN:   return 3'b010;
            CYAN:    return 3'b011;
            BLUE:    return 3'b001;
            MAGENTA: return 3'b101;
            WHITE:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req at or after ptr
// Ports: req (request vector), ptr (search start), gnt (one-hot), gnt_id (index), valid (any req)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_id,
    output logic               valid
);
    logic [IW-1:0] j;

    // Scan from farthest to nearest so the nearest set request wins
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        valid  = 1'b0;
        j      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                gnt_id = j;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: round-robin sharing of one RGB LED, timed display then dark gap
// Ports: clk, rst_n (async active-low), req/color/dur per requester, brightness (PWM duty),
//        ack (one-hot accept), done (display end), busy, grant_id, red/green/blue (LED drive)
// Optional: define RGB_PWM_DIM_EN to gate the colour channels with an 8-bit PWM at brightness
module rgb_led_arbiter
    import rgb_led_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 12000,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 50,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [3*NUM_REQ-1:0]     color,
    input  logic [DUR_W*NUM_REQ-1:0] dur,
    input  logic [7:0]               brightness,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     done,
    output logic                     busy,
    output logic [IW-1:0]            grant_id,
    output logic                     red,
    output logic                     green,
    output logic                     blue
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int GW = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;

    state_t             state, state_d;
    logic [PW-1:0]      presc;
    logic [DUR_W-1:0]   tcnt, dur_q, dmax;
    logic [GW-1:0]      gcnt;
    logic [IW-1:0]      ptr, gnt_id;
    logic [NUM_REQ-1:0] gnt;
    logic [2:0]         rgb_q, rgb_d;
    logic               valid, tick, start, show_end, gap_end, entry;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .valid  (valid)
    );

    always_comb begin
        tick     = presc == PW'(TICK_DIV - 1);
        dmax     = dur_q == '0 ? DUR_W'(1) : dur_q;
        start    = state == IDLE && valid;
        show_end = state == SHOW && tick && tcnt == dmax - DUR_W'(1);
        gap_end  = state == GAP && tick && gcnt == GW'(GAP_TICKS - 1);
        state_d  = start ? SHOW : show_end ? (GAP_TICKS == 0 ? IDLE : GAP) : gap_end ? IDLE : state;
        entry    = state_d != state && state_d != IDLE;
        done     = show_end;
        rgb_d    = start ? decode_color(color_t'(color[int'(gnt_id)*3 +: 3])) : show_end ? 3'b000 : rgb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= '0;
            tcnt     <= '0;
            gcnt     <= '0;
            dur_q    <= '0;
            ptr      <= '0;
            grant_id <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            state <= state_d;
            busy  <= state_d != IDLE;
            ack   <= start ? gnt : '0;
            rgb_q <= rgb_d;
            presc <= (entry || tick) ? '0 : presc + PW'(1);
            tcnt  <= entry ? '0 : (tick && state == SHOW) ? tcnt + DUR_W'(1) : tcnt;
            gcnt  <= entry ? '0 : (tick && state == GAP) ? gcnt + GW'(1) : gcnt;
            if (start) begin
                dur_q    <= dur[int'(gnt_id)*DUR_W +: DUR_W];
                grant_id <= gnt_id;
                ptr      <= gnt_id == IW'(NUM_REQ - 1) ? '0 : gnt_id + IW'(1);
            end
        end
    end

`ifdef RGB_PWM_DIM_EN
    logic [7:0] pwm_cnt;
    logic [2:0] led_q;

    // Gate the next colour so PWM adds no latency to the lit window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led_q   <= rgb_d & {3{pwm_cnt < brightness}};
        end
    end

    assign {red, green, blue} = led_q;
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign {red, green, blue} = rgb_q;
`endif

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed vector and sequence checks for rgb_led_arbiter
module tb_rgb_led_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] color = '1;
    logic [31:0] dur = '0;
    logic [7:0]  brightness = 8'hff;
    logic [3:0]  ack;
    logic        done, busy, red, green, blue;
    logic [1:0]  grant_id;

    int checks = 0;
    int failures = 0;

    rgb_led_arbiter #(.NUM_REQ(4), .TICK_DIV(4), .DUR_W(8), .GAP_TICKS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .color      (color),
        .dur        (dur),
        .brightness (brightness),
        .ack        (ack),
        .done       (done),
        .busy       (busy),
        .grant_id   (grant_id),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] col;
        logic [31:0] dur;
        int          id;
        logic [2:0]  rgb;
        int          len;
    } vec_t;

    vec_t v[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output int n, output bit got);
        n = 0;
        got = 0;
        while (!got && n < limit) begin
            step();
            n++;
            got = ack != '0;
        end
    endtask

    task automatic run_vec(input vec_t t);
        int n;
        bit got;
        do_reset();
        chk("reset_out", {28'd0, red, green, blue, busy}, 0);
        color = t.col;
        dur   = t.dur;
        req   = t.req;
        wait_ack(50, n, got);
        chk("vec_ack_seen", got, 1);
        chk("vec_ack_onehot", ack, 32'd1 << t.id);
        chk("vec_grant_id", grant_id, t.id);
        req = '0;
        for (int i = 0; i < t.len; i++) begin
            chk("vec_lit_rgb", {red, green, blue}, t.rgb);
            chk("vec_lit_done", done, i == t.len - 1);
            chk("vec_lit_busy", busy, 1);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            chk("vec_gap_dark", {red, green, blue, done}, 0);
            chk("vec_gap_busy", busy, 1);
            step();
        end
        chk("vec_idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        bit got;
        int cnt;
        v[0] = '{4'b0001, {3'd7, 3'd7, 3'd7, 3'd2}, {8'd0, 8'd0, 8'd0, 8'd3}, 0, 3'b010, 12};
        v[1] = '{4'b0010, {3'd7, 3'd7, 3'd6, 3'd7}, {8'd0, 8'd0, 8'd0, 8'd0}, 1, 3'b111, 4};
        v[2] = '{4'b0100, {3'd7, 3'd5, 3'd7, 3'd7}, {8'd0, 8'd1, 8'd0, 8'd0}, 2, 3'b101, 4};
        v[3] = '{4'b1000, {3'd3, 3'd7, 3'd7, 3'd7}, {8'd2, 8'd0, 8'd0, 8'd0}, 3, 3'b011, 8};
        v[4] = '{4'b1010, {3'd4, 3'd7, 3'd0, 3'd7}, {8'd1, 8'd0, 8'd1, 8'd0}, 1, 3'b100, 4};
        v[5] = '{4'b1111, {3'd7, 3'd7, 3'd7, 3'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 3'b110, 4};
        v[6] = '{4'b1000, {3'd4, 3'd7, 3'd7, 3'd7}, {8'd1, 8'd0, 8'd0, 8'd0}, 3, 3'b001, 4};
        v[7] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, {8'd0, 8'd0, 8'd0, 8'd1}, 0, 3'b000, 4};
        for (int i = 0; i < 8; i++) run_vec(v[i]);

        // req0 and req2 together: 0 then 2, 21 cycles apart; colour change after ack ignored
        do_reset();
        color = {3'd7, 3'd4, 3'd7, 3'd2};
        dur   = {8'd0, 8'd3, 8'd0, 8'd3};
        req   = 4'b0101;
        wait_ack(50, n, got);
        chk("pair_first_ack", ack, 4'b0001);
        chk("pair_first_id", grant_id, 0);
        req   = 4'b0100;
        color = {3'd7, 3'd4, 3'd7, 3'd6};
        step();
        step();
        chk("pair_color_hold", {red, green, blue}, 3'b010);
        wait_ack(50, n, got);
        chk("pair_second_gap", n + 2, 21);
        chk("pair_second_ack", ack, 4'b0100);
        chk("pair_second_id", grant_id, 2);
        chk("pair_second_rgb", {red, green, blue}, 3'b001);

        // All four held, dur=1: order 0,1,2,3,0 every 13 cycles
        do_reset();
        color = {3'd0, 3'd1, 3'd2, 3'd3};
        dur   = {8'd1, 8'd1, 8'd1, 8'd1};
        req   = 4'b1111;
        wait_ack(50, n, got);
        chk("rr_first_id", grant_id, 0);
        for (int k = 1; k <= 4; k++) begin
            wait_ack(50, n, got);
            chk("rr_spacing", n, 13);
            chk("rr_ack", ack, 32'd1 << (k % 4));
            chk("rr_id", grant_id, k % 4);
        end

        // Request withdrawn before ack is never granted
        do_reset();
        color = '0;
        dur   = {8'd1, 8'd1, 8'd1, 8'd1};
        req   = 4'b0001;
        wait_ack(50, n, got);
        req = 4'b0100;
        step();
        step();
        req = 4'b0000;
        wait_ack(30, n, got);
        chk("withdraw_no_ack", got, 0);

        // Reset mid-SHOW clears outputs at once; pointer back to 0
        do_reset();
        color = {3'd6, 3'd6, 3'd6, 3'd6};
        dur   = {8'd3, 8'd3, 8'd3, 8'd3};
        req   = 4'b0001;
        wait_ack(50, n, got);
        req = 4'b1010;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", {23'd0, red, green, blue, busy, done, ack}, 0);
        step();
        step();
        rst_n = 1'b1;
        wait_ack(50, n, got);
        chk("rst_after_ack", ack, 4'b0010);
        chk("rst_after_id", grant_id, 1);
        req = '0;

`ifdef RGB_PWM_DIM_EN
        do_reset();
        brightness = 8'd64;
        color = {3'd7, 3'd7, 3'd7, 3'd0};
        dur   = {8'd0, 8'd0, 8'd0, 8'd255};
        req   = 4'b0001;
        wait_ack(50, n, got);
        req = '0;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cnt += red;
            chk("pwm_gb_off", {green, blue}, 0);
            step();
        end
        chk("pwm_duty64", cnt, 64);
        brightness = 8'd0;
        step();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cnt += red;
            step();
        end
        chk("pwm_duty0", cnt, 0);
`else
        cnt = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
